// File: rtl/sip_shift_accumulator_pkg.sv
// Shared widths, state encoding and helpers for the SIP shift-accumulator.
package sip_shift_accumulator_pkg;

  localparam int BITS_SIP_DOT_ADDER = 8;
  localparam int BITS_ACC           = 24;
  localparam int BITS_SHIFT         = 4;
  localparam int BITS_NTERM         = 8;
  localparam int MAX_SHIFT          = BITS_ACC - BITS_SIP_DOT_ADDER;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  function automatic logic [BITS_NTERM-1:0] sat_inc(input logic [BITS_NTERM-1:0] v);
    return (v == {BITS_NTERM{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sip_shift_term.sv
// Weights one adder-tree result by its bit significance: sign-extend, shift, negate.
// The term is one bit wider than the accumulator so that negating the most negative value stays exact.
module sip_shift_term #(
  parameter int BITS_IN    = 8,
  parameter int BITS_ACC   = 24,
  parameter int BITS_SHIFT = 4
) (
  input  logic signed [BITS_IN-1:0]    psum_i,
  input  logic        [BITS_SHIFT-1:0] shift_i,
  input  logic                         neg_i,
  output logic signed [BITS_ACC:0]     term_o,
  output logic                         ovf_o
);
  import sip_shift_accumulator_pkg::*;

  localparam int MAX_SH = BITS_ACC - BITS_IN;

  logic        [31:0]         shift_w;
  logic        [31:0]         shift_eff;
  logic                       clamp;
  logic signed [BITS_ACC-1:0] ext;
  logic signed [BITS_ACC-1:0] shifted;
  logic signed [BITS_ACC:0]   wide;

  always_comb begin
    shift_w   = 32'(shift_i);
    clamp     = shift_w > 32'(MAX_SH);
    shift_eff = clamp ? 32'(MAX_SH) : shift_w;
    ext       = BITS_ACC'(psum_i);
    shifted   = ext << shift_eff;
    wide      = {shifted[BITS_ACC-1], shifted};
    term_o    = neg_i ? -wide : wide;
    // Significant bits lost if shifting back does not recover the operand.
    ovf_o     = clamp | ((shifted >>> shift_eff) != ext);
  end

endmodule

// File: rtl/sip_shift_accumulator.sv
// Bit-serial partial-sum accumulator with valid/ready on both sides and a
// one-entry result register that can reload in the cycle it drains.
module sip_shift_accumulator #(
  parameter int BITS_IN    = sip_shift_accumulator_pkg::BITS_SIP_DOT_ADDER,
  parameter int BITS_ACC   = sip_shift_accumulator_pkg::BITS_ACC,
  parameter int BITS_SHIFT = sip_shift_accumulator_pkg::BITS_SHIFT
) (
  input  logic                         i_CLK,
  input  logic                         i_RSTn,
  input  logic                         i_clear,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic signed [BITS_IN-1:0]    i_psum,
  input  logic        [BITS_SHIFT-1:0] i_shift,
  input  logic                         i_neg,
  input  logic                         i_last,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic signed [BITS_ACC-1:0]   o_acc,
  output logic                         o_ovf,
  output logic        [7:0]            o_nterm
);
  import sip_shift_accumulator_pkg::*;

  state_e                     state_q, state_d;
  logic signed [BITS_ACC-1:0] acc_q, acc_d;
  logic        [7:0]          cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;
  logic                       valid_q, valid_d;
  logic signed [BITS_ACC-1:0] res_acc_q, res_acc_d;
  logic                       res_ovf_q, res_ovf_d;
  logic        [7:0]          res_n_q, res_n_d;

  logic signed [BITS_ACC:0]   term;
  logic                       term_ovf;
  logic signed [BITS_ACC-1:0] base;
  logic signed [BITS_ACC:0]   sum_w;
  logic                       add_ovf;
  logic                       grp_ovf;
  logic        [7:0]          grp_cnt;
  logic                       accept;

  sip_shift_term #(
    .BITS_IN   (BITS_IN),
    .BITS_ACC  (BITS_ACC),
    .BITS_SHIFT(BITS_SHIFT)
  ) u_term (
    .psum_i (i_psum),
    .shift_i(i_shift),
    .neg_i  (i_neg),
    .term_o (term),
    .ovf_o  (term_ovf)
  );

  assign o_ready = ~valid_q | i_ready;
  assign accept  = i_valid & o_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    res_acc_d = res_acc_q;
    res_ovf_d = res_ovf_q;
    res_n_d   = res_n_q;

    base    = (state_q == ACCUM) ? acc_q : '0;
    // One guard bit: sum outside the accumulator range shows as a top-bit disagreement.
    sum_w   = {base[BITS_ACC-1], base} + term;
    add_ovf = sum_w[BITS_ACC] ^ sum_w[BITS_ACC-1];
    grp_ovf = ((state_q == ACCUM) & ovf_q) | term_ovf | add_ovf;
    grp_cnt = (state_q == ACCUM) ? sat_inc(cnt_q) : 8'd1;

    if (valid_q & i_ready) valid_d = 1'b0;

    if (i_clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      if (i_last) begin
        res_acc_d = sum_w[BITS_ACC-1:0];
        res_ovf_d = grp_ovf;
        res_n_d   = grp_cnt;
        valid_d   = 1'b1;
        state_d   = IDLE;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
      end else begin
        state_d = ACCUM;
        acc_d   = sum_w[BITS_ACC-1:0];
        cnt_d   = grp_cnt;
        ovf_d   = grp_ovf;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      res_acc_q <= '0;
      res_ovf_q <= 1'b0;
      res_n_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      res_acc_q <= res_acc_d;
      res_ovf_q <= res_ovf_d;
      res_n_q   <= res_n_d;
    end
  end

  assign o_valid = valid_q;
  assign o_acc   = res_acc_q;
  assign o_ovf   = res_ovf_q;
  assign o_nterm = res_n_q;

endmodule
